// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared definitions for the mem_loader slice.
//   state_t         - controller state encoding
//   bytes_per_word  - BPW derivation from the BRAM word width
//   byte_idx_bits   - width of the per-word byte index counter
package mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_BYTE,
    S_LD_WRITE,
    S_DP_ADDR,
    S_DP_WAIT,
    S_DP_SEND,
    S_DONE
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_bits);
    return data_bits / 8;
  endfunction

  // A single-byte word still needs a 1-bit index so the counter is never zero width.
  function automatic int unsigned byte_idx_bits(input int unsigned bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: bundles every non-clock/reset signal of mem_loader.
//   i_start_load/i_start_dump/i_count      transaction control
//   i_byte_valid/i_byte/o_byte_ready       inbound byte stream (LOAD)
//   o_byte_valid/o_byte/i_byte_ready       outbound byte stream (DUMP)
//   o_mem_we/o_mem_addr/o_mem_data         BRAM write port
//   i_mem_data                             BRAM read data
//   o_busy/o_done/o_checksum               status
// Modports: slave = the loader itself, master = the surrounding system.
interface mem_loader_if #(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned DATA_BITS    = 32
) ();

  logic                    i_start_load;
  logic                    i_start_dump;
  logic [ADDRESS_BITS:0]   i_count;

  logic                    i_byte_valid;
  logic [7:0]              i_byte;
  logic                    o_byte_ready;

  logic                    o_byte_valid;
  logic [7:0]              o_byte;
  logic                    i_byte_ready;

  logic                    o_mem_we;
  logic [ADDRESS_BITS-1:0] o_mem_addr;
  logic [DATA_BITS-1:0]    o_mem_data;
  logic [DATA_BITS-1:0]    i_mem_data;

  logic                    o_busy;
  logic                    o_done;
  logic [DATA_BITS-1:0]    o_checksum;

  modport slave (
    input  i_start_load, i_start_dump, i_count,
    input  i_byte_valid, i_byte, i_byte_ready, i_mem_data,
    output o_byte_ready, o_byte_valid, o_byte,
    output o_mem_we, o_mem_addr, o_mem_data,
    output o_busy, o_done, o_checksum
  );

  modport master (
    output i_start_load, i_start_dump, i_count,
    output i_byte_valid, i_byte, i_byte_ready, i_mem_data,
    input  o_byte_ready, o_byte_valid, o_byte,
    input  o_mem_we, o_mem_addr, o_mem_data,
    input  o_busy, o_done, o_checksum
  );

endinterface

// File: rtl/mem_loader_shreg.sv
// mem_loader_shreg: DATA_BITS-wide byte shift register shared by LOAD and DUMP.
//   load/load_data      parallel load (DUMP capture of BRAM read data)
//   shift_in/byte_in    shift left one byte, new byte enters the LSB end
//   shift_out           shift left one byte, zero enters the LSB end
//   word_shifted_in     value the register would hold after a shift_in
//   msb_byte            current most significant byte
// Priority: load > shift_in > shift_out.
module mem_loader_shreg #(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 shift_in,
  input  logic [7:0]           byte_in,
  input  logic                 shift_out,
  output logic [DATA_BITS-1:0] word_shifted_in,
  output logic [7:0]           msb_byte
);

  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] word_shifted_out;

  if (DATA_BITS > 8) begin : g_multi
    assign word_shifted_in  = {word[DATA_BITS-9:0], byte_in};
    assign word_shifted_out = {word[DATA_BITS-9:0], 8'h00};
  end else begin : g_single
    assign word_shifted_in  = byte_in;
    assign word_shifted_out = '0;
  end

  assign msb_byte = word[DATA_BITS-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load) begin
      word <= load_data;
    end else if (shift_in) begin
      word <= word_shifted_in;
    end else if (shift_out) begin
      word <= word_shifted_out;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: moves whole BRAM words to/from a byte stream.
//   LOAD: bytes arrive MSB-first on i_byte, each assembled word is written
//         to consecutive addresses starting at 0.
//   DUMP: words are read from consecutive addresses starting at 0 and sent
//         MSB-first on o_byte with valid/ready flow control.
// Ports: clk, rst_n (async, active-low) and bus (mem_loader_if.slave).
// Parameters: ADDRESS_BITS (BRAM address width), DATA_BITS (word width, multiple of 8).
// Optional feature: define MEM_LOADER_CHECKSUM_EN to XOR-accumulate every
// transferred word into o_checksum; otherwise o_checksum is tied to 0.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 8,
  parameter int unsigned DATA_BITS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_loader_if.slave bus
);

  localparam int unsigned BPW   = bytes_per_word(DATA_BITS);
  localparam int unsigned IDX_W = byte_idx_bits(BPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  state_t                state;
  logic [ADDRESS_BITS:0] cnt;
  logic [ADDRESS_BITS:0] total;
  logic [ADDRESS_BITS:0] cnt_inc;
  logic                  more_words;
  logic [IDX_W-1:0]      byte_idx;

  logic                  ld_fire;
  logic                  dp_fire;
  logic                  sh_load;
  logic [DATA_BITS-1:0]  word_in;
  logic [7:0]            msb_byte;

  // Counter is one bit wider than the address so a count of 2^ADDRESS_BITS
  // terminates instead of wrapping back to address 0.
  assign cnt_inc    = cnt + 1'b1;
  assign more_words = (cnt_inc < total);

  assign ld_fire = (state == S_LD_BYTE) && bus.i_byte_valid && bus.o_byte_ready;
  assign dp_fire = (state == S_DP_SEND) && bus.o_byte_valid && bus.i_byte_ready;
  assign sh_load = (state == S_DP_WAIT);

  mem_loader_shreg #(
    .DATA_BITS(DATA_BITS)
  ) u_shreg (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (sh_load),
    .load_data       (bus.i_mem_data),
    .shift_in        (ld_fire),
    .byte_in         (bus.i_byte),
    .shift_out       (dp_fire),
    .word_shifted_in (word_in),
    .msb_byte        (msb_byte)
  );

  // The outbound byte is the top of the shift register, so it only moves
  // when a byte is accepted and is naturally held while i_byte_ready is low.
  assign bus.o_byte = msb_byte;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_BITS-1:0] checksum_q;
  assign bus.o_checksum = checksum_q;
`else
  assign bus.o_checksum = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      total            <= '0;
      byte_idx         <= '0;
      bus.o_byte_ready <= 1'b0;
      bus.o_byte_valid <= 1'b0;
      bus.o_mem_we     <= 1'b0;
      bus.o_mem_addr   <= '0;
      bus.o_mem_data   <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      checksum_q       <= '0;
`endif
    end else begin
      bus.o_done   <= 1'b0;
      bus.o_mem_we <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.i_start_load || bus.i_start_dump) begin
            cnt      <= '0;
            total    <= bus.i_count;
            byte_idx <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
            if (bus.i_count == '0) begin
              state      <= S_DONE;
              bus.o_done <= 1'b1;
            end else if (bus.i_start_load) begin
              state            <= S_LD_BYTE;
              bus.o_byte_ready <= 1'b1;
              bus.o_busy       <= 1'b1;
            end else begin
              state          <= S_DP_ADDR;
              bus.o_mem_addr <= '0;
              bus.o_busy     <= 1'b1;
            end
          end
        end

        S_LD_BYTE: begin
          if (ld_fire) begin
            if (byte_idx == LAST_IDX) begin
              // Write port is set up from the word including this last byte,
              // so the write happens in the very next cycle.
              byte_idx         <= '0;
              state            <= S_LD_WRITE;
              bus.o_byte_ready <= 1'b0;
              bus.o_mem_we     <= 1'b1;
              bus.o_mem_addr   <= cnt[ADDRESS_BITS-1:0];
              bus.o_mem_data   <= word_in;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

        S_LD_WRITE: begin
          cnt <= cnt_inc;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_q <= checksum_q ^ bus.o_mem_data;
`endif
          if (more_words) begin
            state            <= S_LD_BYTE;
            bus.o_byte_ready <= 1'b1;
          end else begin
            state      <= S_DONE;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
          end
        end

        S_DP_ADDR: begin
          state <= S_DP_WAIT;
        end

        S_DP_WAIT: begin
          state            <= S_DP_SEND;
          bus.o_byte_valid <= 1'b1;
          byte_idx         <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
          checksum_q <= checksum_q ^ bus.i_mem_data;
`endif
        end

        S_DP_SEND: begin
          if (dp_fire) begin
            if (byte_idx == LAST_IDX) begin
              byte_idx         <= '0;
              bus.o_byte_valid <= 1'b0;
              cnt              <= cnt_inc;
              if (more_words) begin
                state          <= S_DP_ADDR;
                bus.o_mem_addr <= cnt_inc[ADDRESS_BITS-1:0];
              end else begin
                state      <= S_DONE;
                bus.o_busy <= 1'b0;
                bus.o_done <= 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state      <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized self-checking bench for mem_loader
// (ADDRESS_BITS=4, DATA_BITS=32). A behavioural BRAM sits on the bus; the
// reference model tracks intended memory contents word by word and derives
// expected writes, byte streams and checksums from them.
module tb_mem_loader;

  localparam int unsigned AB = 4;
  localparam int unsigned DB = 32;
  localparam int unsigned CW = AB + 1;
  localparam int unsigned NW = 1 << AB;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_loader_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) bus ();

  mem_loader #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0]    tx_q[$];
  logic [7:0]    rx_q[$];
  logic [7:0]    bq[$];
  logic [AB-1:0] wr_addr_q[$];
  logic [DB-1:0] wr_data_q[$];
  logic [DB-1:0] bram[NW];
  logic [DB-1:0] ref_mem[NW];

  int unsigned done_cnt = 0;
  int unsigned ld_fires = 0;
  bit          ld_fire_flag = 1'b0;
  int unsigned rdy_mode = 0;
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_byte = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] exp_csum(input logic [DB-1:0] x);
    return CSUM_EN ? x : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor + BRAM: sample at negedge, halfway between active edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend)
          check("dp_hold", {bus.o_byte_valid, bus.o_byte}, {1'b1, hold_byte});
        hold_pend    = bus.o_byte_valid && !bus.i_byte_ready;
        hold_byte    = bus.o_byte;
        ld_fire_flag = bus.i_byte_valid && bus.o_byte_ready;
        if (ld_fire_flag) ld_fires++;
        if (bus.o_byte_valid && bus.i_byte_ready) rx_q.push_back(bus.o_byte);
        if (bus.o_mem_we) begin
          bram[bus.o_mem_addr] = bus.o_mem_data;
          wr_addr_q.push_back(bus.o_mem_addr);
          wr_data_q.push_back(bus.o_mem_data);
        end
        if (bus.o_done) done_cnt++;
      end else begin
        hold_pend    = 1'b0;
        ld_fire_flag = 1'b0;
      end
      bus.i_mem_data = bram[bus.o_mem_addr];
    end
  end

  // Stream driver: random valid gaps on the inbound side, ready pattern per rdy_mode.
  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_byte_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ld_fire_flag && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = tx_q[0];
      end else begin
        bus.i_byte_valid = 1'b0;
        bus.i_byte       = 8'($urandom);
      end
      case (rdy_mode)
        0:       bus.i_byte_ready = 1'b1;
        1:       bus.i_byte_ready = !bus.i_byte_ready;
        default: bus.i_byte_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_byte_ready"}, bus.o_byte_ready, 0);
    check({tag, "_byte_valid"}, bus.o_byte_valid, 0);
    check({tag, "_byte"},       bus.o_byte, 0);
    check({tag, "_mem_we"},     bus.o_mem_we, 0);
    check({tag, "_mem_addr"},   bus.o_mem_addr, 0);
    check({tag, "_mem_data"},   bus.o_mem_data, 0);
    check({tag, "_busy"},       bus.o_busy, 0);
    check({tag, "_done"},       bus.o_done, 0);
    check({tag, "_checksum"},   bus.o_checksum, 0);
  endtask

  task automatic start_txn(input bit ld, input bit dp, input int unsigned n);
    step();
    bus.i_start_load = ld;
    bus.i_start_dump = dp;
    bus.i_count      = CW'(n);
    step();
    bus.i_start_load = 1'b0;
    bus.i_start_dump = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned d0, input int unsigned budget);
    int unsigned n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, bus.o_busy, 0);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int unsigned j = 0; j < 4; j++) bq.push_back(w[31-8*j -: 8]);
  endtask

  // LOAD n words from bq starting at address 0; expectations come from bq.
  task automatic do_load(input string tag, input int unsigned n);
    int unsigned   d0, w0;
    logic [DB-1:0] w, csum;
    d0   = done_cnt;
    w0   = wr_addr_q.size();
    csum = '0;
    foreach (bq[i]) tx_q.push_back(bq[i]);
    start_txn(1'b1, 1'b0, n);
    @(negedge clk);
    check({tag, "_busy"}, bus.o_busy, 1);
    wait_done(tag, d0, 400 * n + 50);
    check({tag, "_nwrites"}, wr_addr_q.size() - w0, n);
    for (int unsigned k = 0; k < n; k++) begin
      w          = {bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
      ref_mem[k] = w;
      csum       = csum ^ w;
      if (w0 + k < wr_addr_q.size()) begin
        check({tag, $sformatf("_addr%0d", k)}, wr_addr_q[w0+k], k);
        check({tag, $sformatf("_data%0d", k)}, wr_data_q[w0+k], w);
      end
    end
    check({tag, "_checksum"}, bus.o_checksum, exp_csum(csum));
  endtask

  // DUMP n words; optionally fire a start pulse mid-transfer that must be ignored.
  task automatic do_dump(input string tag, input int unsigned n, input int unsigned mode, input bit inject);
    int unsigned   d0, r0;
    logic [DB-1:0] w, csum;
    d0       = done_cnt;
    r0       = rx_q.size();
    csum     = '0;
    rdy_mode = mode;
    start_txn(1'b0, 1'b1, n);
    if (inject) begin
      repeat (3) step();
      bus.i_start_load = 1'b1;
      bus.i_count      = '0;
      step();
      bus.i_start_load = 1'b0;
    end
    wait_done(tag, d0, 200 * n + 50);
    check({tag, "_nbytes"}, rx_q.size() - r0, 4 * n);
    for (int unsigned k = 0; k < n; k++) begin
      w    = ref_mem[k];
      csum = csum ^ w;
      for (int unsigned j = 0; j < 4; j++)
        if (r0 + 4*k + j < rx_q.size())
          check({tag, $sformatf("_w%0d_b%0d", k, j)}, rx_q[r0+4*k+j], w[31-8*j -: 8]);
    end
    check({tag, "_checksum"}, bus.o_checksum, exp_csum(csum));
    rdy_mode = 0;
  endtask

  initial begin
    int unsigned d0, w0, f0, n;
    bus.i_start_load = 1'b0;
    bus.i_start_dump = 1'b0;
    bus.i_count      = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      bram[i]    = '0;
      ref_mem[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    step();
    rst_n = 1'b1;

    // Two-word LOAD with the reference byte pattern.
    bq.delete();
    push_word(32'h11223344);
    push_word(32'h55667788);
    do_load("load2", 2);

    // Single-word DUMP of a known word with a toggling ready.
    bram[0]    = 32'hDEADBEEF;
    ref_mem[0] = 32'hDEADBEEF;
    do_dump("dump1", 1, 1, 1'b0);

    // Both starts together with count 0: immediate one-cycle done, no write.
    d0 = done_cnt;
    w0 = wr_addr_q.size();
    start_txn(1'b1, 1'b1, 0);
    @(negedge clk);
    check("zero_done_now", bus.o_done, 1);
    check("zero_busy", bus.o_busy, 0);
    @(negedge clk);
    check("zero_done_gone", bus.o_done, 0);
    check("zero_pulses", done_cnt - d0, 1);
    check("zero_nwrites", wr_addr_q.size() - w0, 0);

    // Reset after two bytes of a LOAD discards the partial word.
    w0 = wr_addr_q.size();
    f0 = ld_fires;
    bq.delete();
    push_word(32'h01020304);
    push_word(32'h05060708);
    foreach (bq[i]) tx_q.push_back(bq[i]);
    start_txn(1'b1, 1'b0, 2);
    n = 0;
    while (ld_fires < f0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    check("mid_rst_nwrites", wr_addr_q.size() - w0, 0);
    check("mid_rst_addr0", bram[0], 32'hDEADBEEF);
    repeat (2) step();
    tx_q.delete();
    step();
    rst_n = 1'b1;
    step();
    bq.delete();
    push_word(32'hA1B2C3D4);
    do_load("after_rst", 1);

    // Complementary words: checksum is all ones when enabled, and holds.
    bq.delete();
    push_word(32'hF0F0F0F0);
    push_word(32'h0F0F0F0F);
    do_load("csum", 2);
    repeat (5) step();
    check("csum_hold", bus.o_checksum, exp_csum(32'hFFFFFFFF));

    // Fill the whole memory with random words.
    bq.delete();
    for (int unsigned k = 0; k < NW; k++) push_word($urandom);
    w0 = wr_addr_q.size();
    do_load("full", NW);
    repeat (10) step();
    check("full_no_extra", wr_addr_q.size() - w0, NW);
    if (wr_addr_q.size() > 0) check("full_last_addr", wr_addr_q[wr_addr_q.size()-1], NW - 1);

    // Full-memory dump plus random-length dumps with random ready.
    do_dump("dump_full", NW, 2, 1'b1);
    for (int unsigned r = 0; r < 4; r++)
      do_dump($sformatf("dump_rnd%0d", r), $urandom_range(1, NW), 2, r[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
